// File: rtl/sensor_priority_sel.sv
// Priority selector: debounced sensors pick a channel command, the master
// switch forces channel 0, and a hold counter limits selection chatter.
module sensor_priority_sel #(
  parameter int N = 16,
  parameter int W = 2,
  parameter int DEB = 3,
  parameter int HOLD = 4,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           m,
  input  logic [N*W-1:0] cmd,
  input  logic [N-1:0]   s,
  output logic [W-1:0]   y,
  output logic [SW-1:0]  sel,
  output logic           switched
);

  localparam int CW = $clog2(DEB + 1);
  localparam int HW = $clog2(HOLD + 1);

  logic [N-1:0]  f;
  logic [CW-1:0] c [N];
  logic [HW-1:0] h;
  logic [HW-1:0] h_next;
  logic [SW-1:0] win;
  logic [SW-1:0] sel_next;
  logic [W-1:0]  cmd_a [N];

  for (genvar g = 0; g < N; g++) begin : g_cmd
    assign cmd_a[g] = cmd[g*W +: W];
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (f[i]) win = SW'(i);
    end
  end

  // Master off overrides the hold window; otherwise only an expired hold
  // lets the sensor winner through.
  always_comb begin
    sel_next = sel;
    if (!m) begin
      sel_next = '0;
    end else if (h == '0) begin
      sel_next = win;
    end
  end

  always_comb begin
    h_next = h;
    if (!m) begin
      h_next = '0;
    end else if (sel_next != sel) begin
      h_next = HW'(HOLD - 1);
    end else if (h != '0) begin
      h_next = h - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f <= '0;
      for (int i = 0; i < N; i++) begin
        c[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s[i] == f[i]) begin
          c[i] <= '0;
        end else if (c[i] == CW'(DEB - 1)) begin
          f[i] <= s[i];
          c[i] <= '0;
        end else begin
          c[i] <= c[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= '0;
      h        <= '0;
      y        <= '0;
      switched <= 1'b0;
    end else begin
      sel      <= sel_next;
      h        <= h_next;
      y        <= cmd_a[sel_next];
      switched <= (sel_next != sel);
    end
  end

endmodule

// File: tb/tb_sensor_priority_sel.sv
// Bench for sensor_priority_sel: directed vector table for the corner
// cases, then random stimulus against a run-length based reference model.
module tb_sensor_priority_sel;

  localparam int N = 16;
  localparam int W = 2;
  localparam int DEB = 3;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m = 1'b1;
  logic [31:0]   cmd = '0;
  logic [15:0]   s = '0;
  logic [1:0]    y;
  logic [3:0]    sel;
  logic          switched;

  int nchk = 0;
  int nerr = 0;

  sensor_priority_sel #(
    .N(N), .W(W), .DEB(DEB), .HOLD(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .m(m),
    .cmd(cmd),
    .s(s),
    .y(y),
    .sel(sel),
    .switched(switched)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        mm;
    logic [15:0] sv;
    logic [31:0] cv;
    int          esel;
    logic [1:0]  ey;
    logic        esw;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a sensor's filtered value follows the raw value once
  // the raw value has been stable for DEB consecutive samples.
  bit   mf [N];
  int   run [N];
  bit   last_s [N];
  int   msel;
  int   mh;
  logic [1:0] my;
  bit   msw;

  task automatic model_step(input bit r, input bit mm,
                            input logic [15:0] ss,
                            input logic [31:0] cc);
    int win;
    int nsel;
    if (r) begin
      for (int i = 0; i < N; i++) begin
        mf[i] = 0;
        run[i] = 0;
        last_s[i] = 0;
      end
      msel = 0;
      mh = 0;
      my = '0;
      msw = 0;
      return;
    end
    win = 0;
    for (int i = 0; i < N; i++) if (mf[i]) win = i;
    if (!mm) nsel = 0;
    else if (mh == 0) nsel = win;
    else nsel = msel;
    if (!mm) mh = 0;
    else if (nsel != msel) mh = HOLD - 1;
    else if (mh > 0) mh = mh - 1;
    msw = (nsel != msel);
    msel = nsel;
    my = cc[nsel*W +: W];
    for (int i = 0; i < N; i++) begin
      if (run[i] > 0 && ss[i] == last_s[i]) run[i] = run[i] + 1;
      else run[i] = 1;
      last_s[i] = ss[i];
      if (ss[i] != mf[i] && run[i] >= DEB) mf[i] = ss[i];
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic mm, input logic [15:0] sv,
                     input logic [31:0] cv, input int esel,
                     input logic [1:0] ey, input logic esw);
    vec_t v;
    v.r = r; v.mm = mm; v.sv = sv; v.cv = cv;
    v.esel = esel; v.ey = ey; v.esw = esw;
    tbl.push_back(v);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(reset, m, s, cmd);
    @(negedge clk);
  endtask

  logic [31:0] c0;
  logic [31:0] c1;

  initial begin
    c0 = '0;
    c0[1:0]   = 2'b01;
    c0[7:6]   = 2'b11;
    c0[15:14] = 2'b01;
    c0[19:18] = 2'b10;
    c0[25:24] = 2'b10;
    c0[31:30] = 2'b11;
    c1 = c0;
    c1[15:14] = 2'b11;

    // reset with all sensors high, then channel 15 four edges after release
    add(1, 1, 16'hFFFF, c0, 0, 2'b00, 0);
    add(1, 1, 16'hFFFF, c0, 0, 2'b00, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 16'hFFFF, c0, 0, 2'b01, 0);
    add(0, 1, 16'hFFFF, c0, 15, 2'b11, 1);
    add(1, 1, 16'h0000, c0, 0, 2'b00, 0);
    // two-cycle glitch on channel 5
    for (int i = 0; i < 2; i++) add(0, 1, 16'h0020, c0, 0, 2'b01, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0000, c0, 0, 2'b01, 0);
    // channels 3 and 9 together
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0208, c0, 0, 2'b01, 0);
    add(0, 1, 16'h0208, c0, 9, 2'b10, 1);
    add(0, 1, 16'h0208, c0, 9, 2'b10, 0);
    // master off during hold, then back on
    add(0, 0, 16'h0208, c0, 0, 2'b01, 1);
    add(0, 1, 16'h0208, c0, 9, 2'b10, 1);
    add(1, 1, 16'h0000, c0, 0, 2'b00, 0);
    // hold window: 3 then 12
    for (int i = 0; i < 2; i++) add(0, 1, 16'h0008, c0, 0, 2'b01, 0);
    add(0, 1, 16'h1008, c0, 0, 2'b01, 0);
    add(0, 1, 16'h1008, c0, 3, 2'b11, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 16'h1008, c0, 3, 2'b11, 0);
    add(0, 1, 16'h1008, c0, 12, 2'b10, 1);
    add(1, 1, 16'h0000, c0, 0, 2'b00, 0);
    // command tracking on channel 7
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0080, c0, 0, 2'b01, 0);
    add(0, 1, 16'h0080, c0, 7, 2'b01, 1);
    add(0, 1, 16'h0080, c1, 7, 2'b11, 0);
    add(0, 1, 16'h0080, c1, 7, 2'b11, 0);

    foreach (tbl[i]) begin
      reset = tbl[i].r;
      m     = tbl[i].mm;
      s     = tbl[i].sv;
      cmd   = tbl[i].cv;
      cycle();
      check($sformatf("row%0d sel", i), int'(sel), tbl[i].esel);
      check($sformatf("row%0d y", i), int'(y), int'(tbl[i].ey));
      check($sformatf("row%0d switched", i), int'(switched), int'(tbl[i].esw));
    end

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    m = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (s[i]) begin
          if ($urandom_range(5) == 0) s[i] = 1'b0;
        end else begin
          if ($urandom_range(39) == 0) s[i] = 1'b1;
        end
      end
      if ($urandom_range(29) == 0) m = ~m;
      if ($urandom_range(3) == 0) cmd = $urandom;
      reset = ($urandom_range(299) == 0);
      cycle();
      check($sformatf("rnd%0d sel", k), int'(sel), msel);
      check($sformatf("rnd%0d y", k), int'(y), int'(my));
      check($sformatf("rnd%0d switched", k), int'(switched), int'(msw));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
